// File: rtl/core_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// core_pkg - shared RISC-X core types and encodings.  Rev 1.0
// ---------------------------------------------------------------------------
package core_pkg;

  typedef enum logic [1:0] {
    BYTE      = 2'b00,
    HALF_WORD = 2'b01,
    WORD      = 2'b10
  } data_type_t;

  typedef enum logic {
    X_REG = 1'b0,
    F_REG = 1'b1
  } reg_bank_mux_t;

  typedef enum logic [1:0] {
    MEM_IDLE        = 2'd0,
    MEM_WAIT_GNT    = 2'd1,
    MEM_WAIT_RVALID = 2'd2,
    MEM_DONE        = 2'd3
  } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lsu_align - byte-enable/store-lane formatting, load shift/extension and the
// misalignment check (active only with RISCX_MISALIGN_TRAP_EN).  Rev 1.0
// ---------------------------------------------------------------------------
module lsu_align
  import core_pkg::*;
(
  input  logic [1:0]  offset,
  input  data_type_t  data_type,
  input  logic        sign_extend,
  input  logic [31:0] store_data,
  input  logic [31:0] load_raw,
  output logic [3:0]  be,
  output logic [31:0] store_lanes,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [31:0] shifted;

  assign shifted = load_raw >> {offset, 3'b000};

  always_comb begin
    be          = 4'b1111;
    store_lanes = store_data;
    load_data   = shifted;
    misaligned  = 1'b0;
    case (data_type)
      BYTE: begin
        be          = 4'b0001 << offset;
        store_lanes = {4{store_data[7:0]}};
        load_data   = {{24{sign_extend & shifted[7]}}, shifted[7:0]};
      end
      HALF_WORD: begin
        // lanes shifted past bit 3 are dropped on a misaligned half-word
        be          = 4'b0011 << offset;
        store_lanes = {2{store_data[15:0]}};
        load_data   = {{16{sign_extend & shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
`ifdef RISCX_MISALIGN_TRAP_EN
    misaligned = ((data_type == HALF_WORD) && offset[0]) ||
                 ((data_type == WORD) && (offset != 2'b00));
`endif
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_stage - EX->MEM pipeline register plus data-memory req/gnt/rvalid FSM.
// Misaligned trap compiled in with RISCX_MISALIGN_TRAP_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module mem_stage
  import core_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic [4:0]    rd_addr_ex_i,
  input  reg_bank_mux_t rd_dst_bank_ex_i,
  input  logic [31:0]   alu_result_ex_i,
  input  logic          mem_req_ex_i,
  input  logic          mem_wen_ex_i,
  input  data_type_t    mem_data_type_ex_i,
  input  logic          mem_sign_extend_ex_i,
  input  logic [31:0]   mem_wdata_ex_i,
  input  logic          reg_alu_wen_ex_i,
  input  logic          reg_mem_wen_ex_i,
  input  logic [31:0]   pc_ex_i,
  input  logic          valid_ex_i,
  input  logic          stall_mem_i,
  input  logic          flush_mem_i,
  output logic          mem_busy_o,
  output logic          trap_mem_o,
  output logic          dmem_req_o,
  output logic          dmem_we_o,
  output logic [3:0]    dmem_be_o,
  output logic [31:0]   dmem_addr_o,
  output logic [31:0]   dmem_wdata_o,
  input  logic          dmem_gnt_i,
  input  logic          dmem_rvalid_i,
  input  logic [31:0]   dmem_rdata_i,
  output logic [4:0]    rd_addr_mem_o,
  output reg_bank_mux_t rd_dst_bank_mem_o,
  output logic [31:0]   alu_result_mem_o,
  output logic [31:0]   mem_rdata_mem_o,
  output logic          reg_alu_wen_mem_o,
  output logic          reg_mem_wen_mem_o,
  output logic          valid_mem_o,
  output logic [31:0]   pc_mem_o
);

  logic [4:0]    rd_addr;
  reg_bank_mux_t rd_dst_bank;
  logic [31:0]   alu_result;
  logic          mem_req;
  logic          mem_wen;
  data_type_t    data_type;
  logic          sign_extend;
  logic [31:0]   wdata;
  logic          reg_alu_wen;
  logic          reg_mem_wen;
  logic [31:0]   pc;
  logic          valid;
  logic [31:0]   rdata_hold;
  mem_state_t    state, state_next;

  logic          issue, busy, capture, eligible, misaligned, stage_load;
  logic [3:0]    be;
  logic [31:0]   store_lanes, load_data;

  lsu_align u_lsu_align (
    .offset      (alu_result[1:0]),
    .data_type   (data_type),
    .sign_extend (sign_extend),
    .store_data  (wdata),
    .load_raw    (capture ? dmem_rdata_i : rdata_hold),
    .be          (be),
    .store_lanes (store_lanes),
    .load_data   (load_data),
    .misaligned  (misaligned)
  );

  assign trap_mem_o = valid & mem_req & misaligned;
  assign eligible   = valid & mem_req & ~trap_mem_o;
  assign stage_load = ~stall_mem_i & ~busy;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_addr     <= '0;
      rd_dst_bank <= X_REG;
      alu_result  <= '0;
      mem_req     <= 1'b0;
      mem_wen     <= 1'b0;
      data_type   <= WORD;
      sign_extend <= 1'b0;
      wdata       <= '0;
      reg_alu_wen <= 1'b0;
      reg_mem_wen <= 1'b0;
      pc          <= '0;
      valid       <= 1'b0;
    end else if (stage_load) begin
      rd_addr     <= rd_addr_ex_i;
      rd_dst_bank <= rd_dst_bank_ex_i;
      alu_result  <= alu_result_ex_i;
      mem_wen     <= mem_wen_ex_i;
      data_type   <= mem_data_type_ex_i;
      sign_extend <= mem_sign_extend_ex_i;
      wdata       <= mem_wdata_ex_i;
      pc          <= pc_ex_i;
      valid       <= valid_ex_i & ~flush_mem_i;
      mem_req     <= mem_req_ex_i & ~flush_mem_i;
      reg_alu_wen <= reg_alu_wen_ex_i & ~flush_mem_i;
      reg_mem_wen <= reg_mem_wen_ex_i & ~flush_mem_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= MEM_IDLE;
      rdata_hold <= '0;
    end else begin
      state <= state_next;
      if (capture) rdata_hold <= dmem_rdata_i;
    end
  end

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    busy       = 1'b0;
    capture    = 1'b0;
    case (state)
      MEM_IDLE: begin
        if (eligible) begin
          issue      = 1'b1;
          busy       = 1'b1;
          state_next = dmem_gnt_i ? MEM_WAIT_RVALID : MEM_WAIT_GNT;
        end
      end
      MEM_WAIT_GNT: begin
        issue = 1'b1;
        busy  = 1'b1;
        if (dmem_gnt_i) state_next = MEM_WAIT_RVALID;
      end
      MEM_WAIT_RVALID: begin
        if (dmem_rvalid_i) begin
          capture    = 1'b1;
          // a stalled stage keeps the result in DONE so the access is not re-issued
          state_next = stall_mem_i ? MEM_DONE : MEM_IDLE;
        end else begin
          busy = 1'b1;
        end
      end
      MEM_DONE: begin
        if (!stall_mem_i) state_next = MEM_IDLE;
      end
      default: state_next = MEM_IDLE;
    endcase
  end

  assign mem_busy_o   = busy;
  assign dmem_req_o   = issue;
  assign dmem_we_o    = issue & mem_wen;
  assign dmem_be_o    = issue ? be : 4'b0000;
  assign dmem_addr_o  = issue ? {alu_result[31:2], 2'b00} : 32'h0;
  assign dmem_wdata_o = issue ? store_lanes : 32'h0;

  assign rd_addr_mem_o     = rd_addr;
  assign rd_dst_bank_mem_o = rd_dst_bank;
  assign alu_result_mem_o  = alu_result;
  assign mem_rdata_mem_o   = load_data;
  assign reg_alu_wen_mem_o = reg_alu_wen & ~trap_mem_o;
  assign reg_mem_wen_mem_o = reg_mem_wen & ~trap_mem_o;
  assign valid_mem_o       = valid;
  assign pc_mem_o          = pc;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_stage - scoreboard bench for mem_stage with a req/gnt/rvalid memory
// model (trap cases follow RISCX_MISALIGN_TRAP_EN).  Rev 1.0
// ---------------------------------------------------------------------------
module tb_mem_stage;
  import core_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } bus_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        is_load;
    logic [31:0] rdata;
    logic        mem_wen;
    logic        alu_wen;
    logic        trap;
  } wb_t;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b0;
  logic [4:0]    rd_addr_ex_i = '0;
  reg_bank_mux_t rd_dst_bank_ex_i = X_REG;
  logic [31:0]   alu_result_ex_i = '0;
  logic          mem_req_ex_i = 1'b0;
  logic          mem_wen_ex_i = 1'b0;
  data_type_t    mem_data_type_ex_i = WORD;
  logic          mem_sign_extend_ex_i = 1'b0;
  logic [31:0]   mem_wdata_ex_i = '0;
  logic          reg_alu_wen_ex_i = 1'b0;
  logic          reg_mem_wen_ex_i = 1'b0;
  logic [31:0]   pc_ex_i = '0;
  logic          valid_ex_i = 1'b0;
  logic          stall_mem_i = 1'b0;
  logic          flush_mem_i = 1'b0;
  logic          mem_busy_o, trap_mem_o, dmem_req_o, dmem_we_o;
  logic [3:0]    dmem_be_o;
  logic [31:0]   dmem_addr_o, dmem_wdata_o;
  logic          dmem_gnt_i = 1'b0;
  logic          dmem_rvalid_i = 1'b0;
  logic [31:0]   dmem_rdata_i = '0;
  logic [4:0]    rd_addr_mem_o;
  reg_bank_mux_t rd_dst_bank_mem_o;
  logic [31:0]   alu_result_mem_o, mem_rdata_mem_o, pc_mem_o;
  logic          reg_alu_wen_mem_o, reg_mem_wen_mem_o, valid_mem_o;

  mem_stage dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .rd_addr_ex_i(rd_addr_ex_i), .rd_dst_bank_ex_i(rd_dst_bank_ex_i),
    .alu_result_ex_i(alu_result_ex_i), .mem_req_ex_i(mem_req_ex_i),
    .mem_wen_ex_i(mem_wen_ex_i), .mem_data_type_ex_i(mem_data_type_ex_i),
    .mem_sign_extend_ex_i(mem_sign_extend_ex_i), .mem_wdata_ex_i(mem_wdata_ex_i),
    .reg_alu_wen_ex_i(reg_alu_wen_ex_i), .reg_mem_wen_ex_i(reg_mem_wen_ex_i),
    .pc_ex_i(pc_ex_i), .valid_ex_i(valid_ex_i),
    .stall_mem_i(stall_mem_i), .flush_mem_i(flush_mem_i),
    .mem_busy_o(mem_busy_o), .trap_mem_o(trap_mem_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .rd_addr_mem_o(rd_addr_mem_o), .rd_dst_bank_mem_o(rd_dst_bank_mem_o),
    .alu_result_mem_o(alu_result_mem_o), .mem_rdata_mem_o(mem_rdata_mem_o),
    .reg_alu_wen_mem_o(reg_alu_wen_mem_o), .reg_mem_wen_mem_o(reg_mem_wen_mem_o),
    .valid_mem_o(valid_mem_o), .pc_mem_o(pc_mem_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_checks = 0;
  int          n_errors = 0;
  bus_t        bus_q[$];
  wb_t         wb_q[$];
  int          gnt_delay = 0;
  int          wait_cnt = 0;
  int          busy_cnt = 0;
  int          req_cnt = 0;
  logic        hs = 1'b0;
  logic [31:0] hs_rdata = '0;
  logic [31:0] pc_next = 32'h1000;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Memory model and both scoreboard monitors: sample at negedge, respond at posedge+1.
  initial begin : mem_side
    bus_t b;
    wb_t  w;
    forever begin
      @(negedge clk_i);
      hs = 1'b0;
      if (rst_n_i) begin
        if (mem_busy_o) busy_cnt++;
        if (dmem_req_o) begin
          req_cnt++;
          if (bus_q.size() == 0) begin
            check_eq("bus_unexpected_req", {31'h0, dmem_req_o}, 32'h0);
          end else begin
            b = bus_q[0];
            check_eq(dmem_gnt_i ? "bus_addr" : "hold_addr", dmem_addr_o, b.addr);
            check_eq(dmem_gnt_i ? "bus_be" : "hold_be", {28'h0, dmem_be_o}, {28'h0, b.be});
            check_eq(dmem_gnt_i ? "bus_we" : "hold_we", {31'h0, dmem_we_o}, {31'h0, b.we});
            check_eq(dmem_gnt_i ? "bus_wdata" : "hold_wdata", dmem_wdata_o, b.wdata);
            if (dmem_gnt_i) begin
              hs       = 1'b1;
              hs_rdata = b.rdata;
              void'(bus_q.pop_front());
            end
          end
        end
        if (valid_mem_o && !stall_mem_i && !mem_busy_o) begin
          if (wb_q.size() == 0) begin
            check_eq("wb_unexpected", {31'h0, valid_mem_o}, 32'h0);
          end else begin
            w = wb_q.pop_front();
            check_eq("wb_pc", pc_mem_o, w.pc);
            check_eq("wb_alu", alu_result_mem_o, w.alu);
            check_eq("wb_rd", {27'h0, rd_addr_mem_o}, {27'h0, w.rd});
            check_eq("wb_mem_wen", {31'h0, reg_mem_wen_mem_o}, {31'h0, w.mem_wen});
            check_eq("wb_alu_wen", {31'h0, reg_alu_wen_mem_o}, {31'h0, w.alu_wen});
            check_eq("wb_trap", {31'h0, trap_mem_o}, {31'h0, w.trap});
            if (w.is_load) check_eq("wb_rdata", mem_rdata_mem_o, w.rdata);
          end
        end
      end
      @(posedge clk_i);
      #1;
      dmem_rvalid_i = hs;
      dmem_rdata_i  = hs ? hs_rdata : 32'h0;
      if (dmem_req_o && rst_n_i) begin
        if (wait_cnt >= gnt_delay) begin
          dmem_gnt_i = 1'b1;
          wait_cnt   = 0;
        end else begin
          dmem_gnt_i = 1'b0;
          wait_cnt++;
        end
      end else begin
        dmem_gnt_i = 1'b0;
        wait_cnt   = 0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the edge that registered it.
  task automatic issue(input logic mr, input logic we, input data_type_t dt, input logic sx,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] mrd,
                       input logic [3:0] xbe, input logic [31:0] xwd, input logic [31:0] xld,
                       input logic xtrap, input logic flush, output int tries);
    bus_t b;
    wb_t  w;
    logic acc;
    pc_next              = pc_next + 32'd4;
    rd_addr_ex_i         = pc_next[6:2];
    rd_dst_bank_ex_i     = X_REG;
    alu_result_ex_i      = addr;
    mem_req_ex_i         = mr;
    mem_wen_ex_i         = we;
    mem_data_type_ex_i   = dt;
    mem_sign_extend_ex_i = sx;
    mem_wdata_ex_i       = wd;
    reg_alu_wen_ex_i     = !mr;
    reg_mem_wen_ex_i     = mr && !we;
    pc_ex_i              = pc_next;
    valid_ex_i           = 1'b1;
    flush_mem_i          = flush;
    if (!flush) begin
      w = '{pc: pc_next, alu: addr, rd: pc_next[6:2], is_load: mr && !we && !xtrap,
            rdata: xld, mem_wen: mr && !we && !xtrap, alu_wen: !mr, trap: xtrap};
      wb_q.push_back(w);
      if (mr && !xtrap) begin
        b = '{addr: {addr[31:2], 2'b00}, be: xbe, we: we, wdata: xwd, rdata: mrd};
        bus_q.push_back(b);
      end
    end
    busy_cnt = 0;
    req_cnt  = 0;
    tries    = 0;
    acc      = 1'b0;
    while (!acc && tries < 64) begin
      @(negedge clk_i);
      acc = !stall_mem_i && !mem_busy_o;
      @(posedge clk_i);
      #1;
      tries++;
    end
    if (!acc) check_eq("accept_timeout", {31'h0, acc}, 32'h1);
    valid_ex_i       = 1'b0;
    mem_req_ex_i     = 1'b0;
    reg_alu_wen_ex_i = 1'b0;
    reg_mem_wen_ex_i = 1'b0;
    flush_mem_i      = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((wb_q.size() != 0 || bus_q.size() != 0) && k < 64) begin
      @(posedge clk_i);
      #1;
      k++;
    end
    if (k >= 64) check_eq("drain_timeout", k, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int tries;
    repeat (2) @(posedge clk_i);
    #1;
    check_eq("rst_req", {31'h0, dmem_req_o}, 32'h0);
    check_eq("rst_we", {31'h0, dmem_we_o}, 32'h0);
    check_eq("rst_be", {28'h0, dmem_be_o}, 32'h0);
    check_eq("rst_addr", dmem_addr_o, 32'h0);
    check_eq("rst_wdata", dmem_wdata_o, 32'h0);
    check_eq("rst_busy", {31'h0, mem_busy_o}, 32'h0);
    check_eq("rst_trap", {31'h0, trap_mem_o}, 32'h0);
    check_eq("rst_valid", {31'h0, valid_mem_o}, 32'h0);
    check_eq("rst_rd", {27'h0, rd_addr_mem_o}, 32'h0);
    check_eq("rst_bank", {31'h0, rd_dst_bank_mem_o}, 32'h0);
    check_eq("rst_alu", alu_result_mem_o, 32'h0);
    check_eq("rst_rdata", mem_rdata_mem_o, 32'h0);
    check_eq("rst_pc", pc_mem_o, 32'h0);
    check_eq("rst_wens", {30'h0, reg_alu_wen_mem_o, reg_mem_wen_mem_o}, 32'h0);
    @(negedge clk_i);
    #1;
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;

    // SW 0xDEADBEEF -> 0x100, gnt same cycle
    gnt_delay = 0;
    issue(1, 1, WORD, 0, 32'h100, 32'hDEAD_BEEF, 32'h0, 4'hF, 32'hDEAD_BEEF, 32'h0, 0, 0, tries);
    drain();
    check_eq("sw_busy_cycles", busy_cnt, 1);

    // LB / LBU from 0x103
    issue(1, 0, BYTE, 1, 32'h103, 32'h0, 32'h80FF_0000, 4'h8, 32'h0, 32'hFFFF_FF80, 0, 0, tries);
    drain();
    issue(1, 0, BYTE, 0, 32'h103, 32'h0, 32'h80FF_0000, 4'h8, 32'h0, 32'h0000_0080, 0, 0, tries);
    drain();
    issue(1, 0, HALF_WORD, 1, 32'h102, 32'h0, 32'h8001_0000, 4'hC, 32'h0, 32'hFFFF_8001, 0, 0, tries);
    drain();
    issue(1, 1, BYTE, 0, 32'h101, 32'h0000_005A, 32'h0, 4'h2, 32'h5A5A_5A5A, 32'h0, 0, 0, tries);
    drain();

    // SH 0x1234 -> 0x202 with gnt held off 3 cycles
    gnt_delay = 3;
    issue(1, 1, HALF_WORD, 0, 32'h202, 32'hABCD_1234, 32'h0, 4'hC, 32'h1234_1234, 32'h0, 0, 0, tries);
    drain();
    check_eq("sh_busy_cycles", busy_cnt, 4);
    check_eq("sh_req_cycles", req_cnt, 4);
    gnt_delay = 0;

    // LW completing under stall: DONE, no re-issue, data held
    issue(1, 0, WORD, 0, 32'h300, 32'h0, 32'hCAFE_F00D, 4'hF, 32'h0, 32'hCAFE_F00D, 0, 0, tries);
    stall_mem_i = 1'b1;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    check_eq("done_state", {30'h0, dut.state}, {30'h0, MEM_DONE});
    check_eq("done_req", {31'h0, dmem_req_o}, 32'h0);
    check_eq("done_busy", {31'h0, mem_busy_o}, 32'h0);
    check_eq("done_rdata", mem_rdata_mem_o, 32'hCAFE_F00D);
    @(posedge clk_i); #1;
    check_eq("done_rdata_hold", mem_rdata_mem_o, 32'hCAFE_F00D);
    check_eq("done_valid", {31'h0, valid_mem_o}, 32'h1);
    stall_mem_i = 1'b0;
    drain();
    check_eq("done_req_count", req_cnt, 1);

    // Misaligned LW at 0x101
`ifdef RISCX_MISALIGN_TRAP_EN
    issue(1, 0, WORD, 0, 32'h101, 32'h0, 32'h1122_3344, 4'hF, 32'h0, 32'h0, 1, 0, tries);
    check_eq("mis_trap", {31'h0, trap_mem_o}, 32'h1);
    check_eq("mis_no_req", {31'h0, dmem_req_o}, 32'h0);
    drain();
    check_eq("mis_req_count", req_cnt, 0);
`else
    issue(1, 0, WORD, 0, 32'h101, 32'h0, 32'h1122_3344, 4'hF, 32'h0, 32'h0011_2233, 0, 0, tries);
    check_eq("mis_trap", {31'h0, trap_mem_o}, 32'h0);
    drain();
    check_eq("mis_req_count", req_cnt, 1);
`endif

    // Flow-through of non-memory instructions
    for (int i = 0; i < 3; i++) begin
      issue(0, 0, WORD, 0, 32'h5000 + 32'(i), 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 0, 0, tries);
      check_eq("flow_tries", tries, 1);
      check_eq("flow_valid", {31'h0, valid_mem_o}, 32'h1);
    end
    drain();

    // Flush inserts a bubble
    issue(0, 0, WORD, 0, 32'h6000, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 0, 1, tries);
    check_eq("flush_valid", {31'h0, valid_mem_o}, 32'h0);
    check_eq("flush_alu_wen", {31'h0, reg_alu_wen_mem_o}, 32'h0);

    // Reset while waiting for gnt
    gnt_delay = 1000;
    issue(1, 1, WORD, 0, 32'h400, 32'h1111_2222, 32'h0, 4'hF, 32'h1111_2222, 32'h0, 0, 0, tries);
    @(posedge clk_i); #1;
    check_eq("wg_req", {31'h0, dmem_req_o}, 32'h1);
    #2;
    rst_n_i = 1'b0;
    #1;
    check_eq("rst_mid_req", {31'h0, dmem_req_o}, 32'h0);
    check_eq("rst_mid_busy", {31'h0, mem_busy_o}, 32'h0);
    check_eq("rst_mid_valid", {31'h0, valid_mem_o}, 32'h0);
    check_eq("rst_mid_state", {30'h0, dut.state}, {30'h0, MEM_IDLE});
    bus_q.delete();
    wb_q.delete();
    @(negedge clk_i);
    #1;
    rst_n_i   = 1'b1;
    gnt_delay = 0;
    @(posedge clk_i); #1;

    // Post-reset access still works
    issue(1, 0, HALF_WORD, 0, 32'h502, 32'h0, 32'hBEEF_0000, 4'hC, 32'h0, 32'h0000_BEEF, 0, 0, tries);
    drain();
    check_eq("post_rst_busy", busy_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
